// File: rtl/seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// seven_seg_scanner
//
// Multiplexed seven-segment display driver (Nexys 4 DDR, 8 digits by default).
// The divided clock from the clock divisor arrives on scan_clock and is treated
// purely as data. It is synchronised into In_clok and edge-detected, and the
// display advances one digit per rising edge. Each frame (digit 0 .. digit
// NUM_DIGITS-1) shows a coherent snapshot of value / dp_mask / digit_enable
// that is captured when digit 0 is selected.
//
// Optional build macro: SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
//   When defined, each snapshot also records the index of the most significant
//   nonzero nibble. Digits above it are blanked, decimal point included. Digit
//   0 is never blanked by this rule.
//
// Ports:
//   In_clok       in   1             system clock (only clock in the block)
//   reset         in   1             asynchronous active-high reset
//   scan_clock    in   1             divided clock, sampled as data
//   value         in   4*NUM_DIGITS  hex value, nibble i -> digit i (0 = right)
//   dp_mask       in   NUM_DIGITS    1 lights decimal point of digit i
//   digit_enable  in   NUM_DIGITS    0 blanks digit i
//   anodes        out  NUM_DIGITS    active-low digit select, one-hot-low
//   segments      out  7             active-low {g,f,e,d,c,b,a}
//   dp            out  1             active-low decimal point
//   scan_tick     out  1             one-cycle pulse per digit advance
// -----------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    In_clok,
    input  logic                    reset,
    input  logic                    scan_clock,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [NUM_DIGITS-1:0]   digit_enable,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [6:0]              segments,
    output logic                    dp,
    output logic                    scan_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Hex nibble to active-low {g..a} glyph.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
    // Index of the highest nonzero nibble; 0 when the whole value is zero.
    function automatic logic [IDX_W-1:0] msd_of(input logic [4*NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] m;
        m = IDX_ZERO;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            m = (v[i*4 +: 4] != 4'h0) ? IDX_W'(i) : m;
        end
        return m;
    endfunction

    logic [IDX_W-1:0] msd_r;
`endif

    logic [SYNC_STAGES-1:0]  sync_r;
    logic                    edge_r;
    logic                    tick_r;
    logic [IDX_W-1:0]        index_r;
    logic [4*NUM_DIGITS-1:0] val_snap_r;
    logic [NUM_DIGITS-1:0]   dp_snap_r;
    logic [NUM_DIGITS-1:0]   en_snap_r;
    logic [NUM_DIGITS-1:0]   anodes_r;
    logic [6:0]              segments_r;
    logic                    dp_r;

    logic [IDX_W-1:0]        next_idx_s;
    logic                    frame_start_s;
    logic [4*NUM_DIGITS-1:0] cur_val_s;
    logic [NUM_DIGITS-1:0]   cur_dp_s;
    logic [NUM_DIGITS-1:0]   cur_en_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              nib_s;
    logic                    dp_bit_s;
    logic                    en_bit_s;
    logic                    lit_s;
    logic [NUM_DIGITS-1:0]   anodes_nx_s;
    logic [6:0]              segments_nx_s;
    logic                    dp_nx_s;

    // Synchronise scan_clock, remember the previous synced level, register the rising edge.
    always_ff @(posedge In_clok or posedge reset) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            edge_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], scan_clock};
            edge_r <= sync_r[SYNC_STAGES-1];
            tick_r <= sync_r[SYNC_STAGES-1] & ~edge_r;
        end
    end

    // Select the next digit and its data; digit 0 reads the live inputs so the
    // frame's first digit agrees with the snapshot taken on the same edge.
    always_comb begin
        next_idx_s    = (index_r == LAST_IDX) ? IDX_ZERO : (index_r + IDX_ONE);
        frame_start_s = (next_idx_s == IDX_ZERO);
        cur_val_s     = frame_start_s ? value        : val_snap_r;
        cur_dp_s      = frame_start_s ? dp_mask      : dp_snap_r;
        cur_en_s      = frame_start_s ? digit_enable : en_snap_r;
        onehot_s      = {NUM_DIGITS{1'b0}};
        nib_s         = 4'h0;
        dp_bit_s      = 1'b0;
        en_bit_s      = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (next_idx_s == IDX_W'(i));
            nib_s       = nib_s | (onehot_s[i] ? cur_val_s[i*4 +: 4] : 4'h0);
            dp_bit_s    = dp_bit_s | (onehot_s[i] & cur_dp_s[i]);
            en_bit_s    = en_bit_s | (onehot_s[i] & cur_en_s[i]);
        end
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
        // At a frame start next_idx_s is 0, so the stale msd_r can never blank it.
        lit_s = en_bit_s & ~(next_idx_s > msd_r);
`else
        lit_s = en_bit_s;
`endif
        anodes_nx_s   = lit_s ? ~onehot_s          : {NUM_DIGITS{1'b1}};
        segments_nx_s = lit_s ? hex_glyph(nib_s)   : 7'b1111111;
        dp_nx_s       = lit_s ? ~dp_bit_s          : 1'b1;
    end

    // Digit index and frame snapshot, advanced on each scan tick.
    always_ff @(posedge In_clok or posedge reset) begin
        if (reset) begin
            index_r    <= LAST_IDX;
            val_snap_r <= {(4*NUM_DIGITS){1'b0}};
            dp_snap_r  <= {NUM_DIGITS{1'b0}};
            en_snap_r  <= {NUM_DIGITS{1'b0}};
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
            msd_r      <= IDX_ZERO;
`endif
        end else if (tick_r) begin
            index_r <= next_idx_s;
            if (frame_start_s) begin
                val_snap_r <= value;
                dp_snap_r  <= dp_mask;
                en_snap_r  <= digit_enable;
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
                msd_r      <= msd_of(value);
`endif
            end
        end
    end

    // Registered display outputs; dark during and right after reset.
    always_ff @(posedge In_clok or posedge reset) begin
        if (reset) begin
            anodes_r   <= {NUM_DIGITS{1'b1}};
            segments_r <= 7'b1111111;
            dp_r       <= 1'b1;
        end else if (tick_r) begin
            anodes_r   <= anodes_nx_s;
            segments_r <= segments_nx_s;
            dp_r       <= dp_nx_s;
        end
    end

    assign anodes    = anodes_r;
    assign segments  = segments_r;
    assign dp        = dp_r;
    assign scan_tick = tick_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Table of per-tick vectors {optional reset, inputs, expected display}. Each
// vector's expectation is queued before scan_clock is pulsed; a monitor pops
// and compares one entry on the cycle after every scan_tick. Hand-written
// sequences cover reset, frozen scan_clock timing and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int ND = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          scan_clock;
    logic [31:0]   value;
    logic [7:0]    dp_mask;
    logic [7:0]    digit_enable;
    logic [7:0]    anodes;
    logic [6:0]    segments;
    logic          dp;
    logic          scan_tick;

    seven_seg_scanner #(.NUM_DIGITS(ND), .SYNC_STAGES(SS)) dut (
        .In_clok      (clk),
        .reset        (reset),
        .scan_clock   (scan_clock),
        .value        (value),
        .dp_mask      (dp_mask),
        .digit_enable (digit_enable),
        .anodes       (anodes),
        .segments     (segments),
        .dp           (dp),
        .scan_tick    (scan_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic [31:0] val;
        logic [7:0]  dpm;
        logic [7:0]  en;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpx;
    } vec_t;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dpx;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb_q[$];
    logic [6:0] glyph [16];
    int         checks = 0;
    int         failures = 0;
    bit         pend = 1'b0;
    int         group1_end;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic rb, input logic [31:0] v, input logic [7:0] dpm,
                                    input logic [7:0] en, input logic [7:0] an,
                                    input logic [6:0] seg, input logic dpx);
        vec_t t;
        t.rst_before = rb; t.val = v; t.dpm = dpm; t.en = en;
        t.an = an; t.seg = seg; t.dpx = dpx;
        vecs.push_back(t);
    endfunction

    // Scoreboard monitor: outputs update on the edge where scan_tick is high.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (pend) begin
            pend = 1'b0;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tick actual=anodes %h required=no tick", anodes);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_anodes",   32'(anodes),   32'(e.an));
                check_val("sb_segments", 32'(segments), 32'(e.seg));
                check_val("sb_dp",       32'(dp),       32'(e.dpx));
            end
        end
        if (scan_tick === 1'b1) pend = 1'b1;
    end

    task automatic pulse();
        @(negedge clk) scan_clock = 1'b1;
        repeat (5) @(negedge clk);
        scan_clock = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (sb_q.size() == 0 && !pend) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_timeout actual=%0d pending required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        #1;
        check_val("rst_anodes",   32'(anodes),    32'h0000_00FF);
        check_val("rst_segments", 32'(segments),  32'h0000_007F);
        check_val("rst_dp",       32'(dp),        32'h0000_0001);
        check_val("rst_tick",     32'(scan_tick), 32'h0000_0000);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk) scan_clock = ~scan_clock;
        end
        check_val("rst_hold_anodes", 32'(anodes),    32'h0000_00FF);
        check_val("rst_hold_tick",   32'(scan_tick), 32'h0000_0000);
        scan_clock = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        pend = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        exp_t e;
        for (int k = lo; k < hi; k++) begin
            if (vecs[k].rst_before) do_reset();
            @(negedge clk);
            value        = vecs[k].val;
            dp_mask      = vecs[k].dpm;
            digit_enable = vecs[k].en;
            e.an = vecs[k].an; e.seg = vecs[k].seg; e.dpx = vecs[k].dpx;
            sb_q.push_back(e);
            pulse();
            drain();
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] v;
        logic [7:0]  an;
        logic        lit;
        int          first_at;
        int          got;

        glyph = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                  7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                  7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        scan_clock = 1'b0; value = 32'h0; dp_mask = 8'h00; digit_enable = 8'h00;

        // Group 1: full frame of 89ABCDEF plus wrap; dp on digits 0 and 2.
        v = 32'h89AB_CDEF;
        for (int d = 0; d < 9; d++) begin
            int i;
            i  = d % 8;
            an = ~(8'd1 << i);
            add_vec(1'b0, v, 8'h05, 8'hFF, an, glyph[v[i*4 +: 4]], (i == 0 || i == 2) ? 1'b0 : 1'b1);
        end
        group1_end = vecs.size();
        // Group 2: value changes mid-frame (after digit 3), new value only at next frame.
        for (int d = 0; d < 9; d++) begin
            int i;
            i  = d % 8;
            an = ~(8'd1 << i);
            add_vec(d == 0, (d < 4) ? 32'h1111_1111 : 32'h2222_2222, 8'h00, 8'hFF, an,
                    (d < 8) ? glyph[1] : glyph[2], 1'b1);
        end
        // Group 3: low digits disabled (dp bit on a disabled digit stays dark).
        for (int d = 0; d < 9; d++) begin
            int i;
            i  = d % 8;
            an = ~(8'd1 << i);
            add_vec(d == 0, 32'h0, 8'h01, 8'hF0, (i < 4) ? 8'hFF : an,
                    (i < 4) ? 7'h7F : glyph[0], 1'b1);
        end
        // Group 4: leading zeros, 00000120 then 00000000.
        for (int d = 0; d < 16; d++) begin
            int i;
            i  = d % 8;
            v  = (d < 8) ? 32'h0000_0120 : 32'h0;
            an = ~(8'd1 << i);
`ifdef SEVEN_SEG_SCANNER_LEADING_ZERO_BLANK_EN
            lit = (d < 8) ? (i <= 2) : (i == 0);
`else
            lit = 1'b1;
`endif
            add_vec(d == 0, v, 8'h00, 8'hFF, lit ? an : 8'hFF,
                    lit ? glyph[v[i*4 +: 4]] : 7'h7F, 1'b1);
        end

        do_reset();
        run_vecs(0, group1_end);

        // Frozen scan_clock: one tick, SYNC_STAGES+1 edges after the rise, digit stays lit.
        begin
            exp_t e;
            e.an = 8'hFD; e.seg = glyph[14]; e.dpx = 1'b1;
            sb_q.push_back(e);
        end
        first_at = -1;
        got = 0;
        @(negedge clk) scan_clock = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (scan_tick === 1'b1) begin
                got++;
                if (first_at < 0) first_at = c;
            end
        end
        check_val("frozen_tick_latency", 32'(first_at), 32'(SS + 1));
        check_val("frozen_tick_count",   32'(got),      32'd1);
        check_val("frozen_anodes_held",  32'(anodes),   32'h0000_00FD);
        @(negedge clk) scan_clock = 1'b0;
        drain();

        // Remaining groups start with a reset while digit 1 is lit.
        run_vecs(group1_end, vecs.size());
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
